// File: rtl/vrb_arb_2to1.sv
// Two-master (IFU/LSU) to one-slave valid/ready arbiter: round-robin with lock-on-stall
// on the command path, and an in-order ID FIFO that steers slave responses back.
module vrb_arb_2to1 #(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int OUTS = 2
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            i_m0_cmd_valid,
    output logic            o_m0_cmd_ready,
    input  logic [AW-1:0]   i_m0_cmd_addr,
    input  logic            i_m0_cmd_read,
    input  logic [DW-1:0]   i_m0_cmd_wdata,
    input  logic [DW/8-1:0] i_m0_cmd_wmask,
    output logic            o_m0_rsp_valid,
    input  logic            i_m0_rsp_ready,
    output logic            o_m0_rsp_err,
    output logic [DW-1:0]   o_m0_rsp_rdata,

    input  logic            i_m1_cmd_valid,
    output logic            o_m1_cmd_ready,
    input  logic [AW-1:0]   i_m1_cmd_addr,
    input  logic            i_m1_cmd_read,
    input  logic [DW-1:0]   i_m1_cmd_wdata,
    input  logic [DW/8-1:0] i_m1_cmd_wmask,
    output logic            o_m1_rsp_valid,
    input  logic            i_m1_rsp_ready,
    output logic            o_m1_rsp_err,
    output logic [DW-1:0]   o_m1_rsp_rdata,

    output logic            o_s_cmd_valid,
    input  logic            i_s_cmd_ready,
    output logic [AW-1:0]   o_s_cmd_addr,
    output logic            o_s_cmd_read,
    output logic [DW-1:0]   o_s_cmd_wdata,
    output logic [DW/8-1:0] o_s_cmd_wmask,
    input  logic            i_s_rsp_valid,
    output logic            o_s_rsp_ready,
    input  logic            i_s_rsp_err,
    input  logic [DW-1:0]   i_s_rsp_rdata
);

    localparam int PW = $clog2(OUTS);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCK0,
        ST_LOCK1
    } state_t;

    state_t        r_state;
    logic          r_last;
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_ids [OUTS];

    logic w_sel;
    logic w_sel_valid;
    logic w_full;
    logic w_empty;
    logic w_cmd_hs;
    logic w_head_id;
    logic w_rsp_hs;

    // NOTE: w_sel gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_sel = ~r_last;
        case (r_state)
            ST_LOCK0: w_sel = 1'b0;
            ST_LOCK1: w_sel = 1'b1;
            default: begin
                if (i_m0_cmd_valid ^ i_m1_cmd_valid) w_sel = i_m1_cmd_valid;
            end
        endcase
    end

    assign w_sel_valid = w_sel ? i_m1_cmd_valid : i_m0_cmd_valid;
    assign w_full      = (r_count == CW'(OUTS));
    assign w_empty     = (r_count == '0);
    assign w_cmd_hs    = w_sel_valid & i_s_cmd_ready & ~w_full;

    // Reset is folded into the visible handshake signals so nothing is offered while held.
    assign o_s_cmd_valid  = w_sel_valid & ~w_full & rst_n;
    assign o_m0_cmd_ready = ~w_sel & i_s_cmd_ready & ~w_full & rst_n;
    assign o_m1_cmd_ready =  w_sel & i_s_cmd_ready & ~w_full & rst_n;
    assign o_s_cmd_addr   = w_sel ? i_m1_cmd_addr  : i_m0_cmd_addr;
    assign o_s_cmd_read   = w_sel ? i_m1_cmd_read  : i_m0_cmd_read;
    assign o_s_cmd_wdata  = w_sel ? i_m1_cmd_wdata : i_m0_cmd_wdata;
    assign o_s_cmd_wmask  = w_sel ? i_m1_cmd_wmask : i_m0_cmd_wmask;

    assign w_head_id      = r_ids[r_head];
    assign o_m0_rsp_valid = i_s_rsp_valid & ~w_empty & ~w_head_id;
    assign o_m1_rsp_valid = i_s_rsp_valid & ~w_empty &  w_head_id;
    assign o_s_rsp_ready  = w_empty | (w_head_id ? i_m1_rsp_ready : i_m0_rsp_ready);
    assign w_rsp_hs       = i_s_rsp_valid & o_s_rsp_ready & ~w_empty;
    assign o_m0_rsp_rdata = i_s_rsp_rdata;
    assign o_m1_rsp_rdata = i_s_rsp_rdata;
    assign o_m0_rsp_err   = i_s_rsp_err & o_m0_rsp_valid;
    assign o_m1_rsp_err   = i_s_rsp_err & o_m1_rsp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b0;
        end else if (w_cmd_hs) begin
            r_state <= ST_IDLE;
            r_last  <= w_sel;
        end else if (r_state == ST_IDLE && w_sel_valid) begin
            r_state <= w_sel ? ST_LOCK1 : ST_LOCK0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_cmd_hs) r_tail <= r_tail + 1'b1;
            if (w_rsp_hs) r_head <= r_head + 1'b1;
            case ({w_cmd_hs, w_rsp_hs})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: ID storage is deliberately unreset; an entry is only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (w_cmd_hs) r_ids[r_tail] <= w_sel;
    end

endmodule
